// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline control logic.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot destination-register shift register (EX, MEM, WB) with
// per-operand match flags for the instruction currently in ID.
module hazard_scoreboard
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [4:0] dst,
  input  logic       is_load,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       hit_ex_a,
  output logic       hit_mem_a,
  output logic       hit_wb_a,
  output logic       hit_ex_b,
  output logic       hit_mem_b,
  output logic       hit_wb_b,
  output logic       ld_ex
);

  sb_entry_t s_ex, s_mem, s_wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ex  <= '0;
      s_mem <= '0;
      s_wb  <= '0;
    end else begin
      s_wb  <= s_mem;
      s_mem <= s_ex;
      s_ex  <= {push, dst, is_load};
    end
  end

  // $0 is hard-wired zero, so a read of it never depends on anything in flight.
  function automatic logic hit(input sb_entry_t e, input logic [4:0] r);
    return e.v && (e.rd == r) && (r != 5'd0);
  endfunction

  always_comb begin
    hit_ex_a  = hit(s_ex, rs);
    hit_mem_a = hit(s_mem, rs);
    hit_wb_a  = hit(s_wb, rs);
    hit_ex_b  = uses_rt & hit(s_ex, rt);
    hit_mem_b = uses_rt & hit(s_mem, rt);
    hit_wb_b  = uses_rt & hit(s_wb, rt);
    ld_ex     = s_ex.v & s_ex.ld;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall/bubble, redirect flush, event counters.
// Define PIPE_HAZARD_FWD_EN to enable EX/MEM and MEM/WB forwarding (load-use stall only).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_wr,
  input  logic [4:0]       id_dst,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             bubble,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Redirect cycle itself is the first flush cycle; the counter covers the rest.
  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [1:0] fl_cnt;
  logic       hazard;
  logic       push;
  logic       hit_ex_a, hit_mem_a, hit_wb_a;
  logic       hit_ex_b, hit_mem_b, hit_wb_b;
  logic       ld_ex;

  assign push = id_valid & id_wr & ~stall & ~flush_id & (id_dst != 5'd0);

  hazard_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .dst       (id_dst),
    .is_load   (id_is_load),
    .rs        (id_rs),
    .rt        (id_rt),
    .uses_rt   (id_uses_rt),
    .hit_ex_a  (hit_ex_a),
    .hit_mem_a (hit_mem_a),
    .hit_wb_a  (hit_wb_a),
    .hit_ex_b  (hit_ex_b),
    .hit_mem_b (hit_mem_b),
    .hit_wb_b  (hit_wb_b),
    .ld_ex     (ld_ex)
  );

`ifdef PIPE_HAZARD_FWD_EN
  // WB results reach ID through the register-file write-through path.
  logic unused_wb;
  assign unused_wb = hit_wb_a | hit_wb_b;
  assign hazard    = ld_ex & (hit_ex_a | hit_ex_b);

  always_comb begin
    fwd_a = FWD_REG;
    if (hit_ex_a)       fwd_a = FWD_EXMEM;
    else if (hit_mem_a) fwd_a = FWD_MEMWB;
    fwd_b = FWD_REG;
    if (hit_ex_b)       fwd_b = FWD_EXMEM;
    else if (hit_mem_b) fwd_b = FWD_MEMWB;
  end
`else
  logic unused_ld;
  assign unused_ld = ld_ex;
  assign hazard    = hit_ex_a | hit_mem_a | hit_wb_a | hit_ex_b | hit_mem_b | hit_wb_b;
  assign fwd_a     = FWD_REG;
  assign fwd_b     = FWD_REG;
`endif

  always_comb begin
    flush_if = ~rst & (ex_redirect | (state == FLUSH));
    flush_id = flush_if;
    stall    = ~rst & id_valid & hazard & ~flush_if;
    bubble   = stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      fl_cnt <= '0;
    end else if (ex_redirect) begin
      fl_cnt <= FL_RELOAD;
      state  <= (FL_RELOAD != 2'd0) ? FLUSH : RUN;
    end else begin
      case (state)
        RUN:  if (stall)  state <= HOLD;
        HOLD: if (!stall) state <= RUN;
        FLUSH: begin
          if (fl_cnt <= 2'd1) begin
            fl_cnt <= '0;
            state  <= RUN;
          end else begin
            fl_cnt <= fl_cnt - 2'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))       stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl; expected outputs are queued with each stimulus row.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int unsigned CW = 4;

  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_STALL = 8'hC0;
  localparam logic [7:0] O_FLUSH = 8'h30;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rt, id_wr, id_is_load, ex_redirect;
  logic [4:0]    id_rs, id_rt, id_dst;
  logic          stall, bubble, flush_if, flush_id;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [7:0]    outs;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_wr(id_wr), .id_dst(id_dst), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .stall(stall), .bubble(bubble), .flush_if(flush_if),
    .flush_id(flush_id), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  assign outs = {stall, bubble, flush_if, flush_id, fwd_a, fwd_b};

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       wr;
    logic [4:0] dst;
    logic       ld;
    logic       redir;
  } stim_t;

  logic [7:0]  exp_q[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;

  function automatic stim_t ins(input int v, rs, rt, urt, wr, dst, ld, redir);
    stim_t s;
    s.v = 1'(v); s.rs = 5'(rs); s.rt = 5'(rt); s.urt = 1'(urt);
    s.wr = 1'(wr); s.dst = 5'(dst); s.ld = 1'(ld); s.redir = 1'(redir);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt;
    id_wr = s.wr; id_dst = s.dst; id_is_load = s.ld; ex_redirect = s.redir;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(ins(1, 3, 3, 1, 1, 3, 1, 1));
    @(negedge clk);
    checks++; if (outs !== O_NONE) begin fails++; $display("FAIL reset_outs: got %b expected %b", outs, O_NONE); end
    checks++; if (stall_cnt !== '0) begin fails++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (flush_cnt !== '0) begin fails++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_raw_alu();
    stim_t st[6]; logic [7:0] ex[6]; logic [7:0] e; int n; logic [CW-1:0] sc;
    do_reset();
    st[0] = ins(1, 1, 2, 1, 1, 3, 0, 0); ex[0] = O_NONE;
    if (FWD) begin
      st[1] = ins(1, 3, 5, 1, 1, 4, 0, 0); ex[1] = 8'h04;
      st[2] = ins(0, 0, 0, 0, 0, 0, 0, 0); ex[2] = O_NONE;
      n = 3; sc = 0;
    end else begin
      for (int i = 1; i < 5; i++) begin st[i] = ins(1, 3, 5, 1, 1, 4, 0, 0); ex[i] = O_STALL; end
      ex[4] = O_NONE;
      st[5] = ins(0, 0, 0, 0, 0, 0, 0, 0); ex[5] = O_NONE;
      n = 6; sc = 3;
    end
    for (int i = 0; i < n; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (outs !== e) begin fails++; $display("FAIL raw_alu row %0d: outs=%b expected %b", i, outs, e); end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt !== sc) begin fails++; $display("FAIL raw_alu_stall_cnt: got %0d expected %0d", stall_cnt, sc); end
  endtask

  task automatic test_load_use();
    stim_t st[6]; logic [7:0] ex[6]; logic [7:0] e; int n; logic [CW-1:0] sc;
    do_reset();
    st[0] = ins(1, 0, 8, 0, 1, 8, 1, 0); ex[0] = O_NONE;
    if (FWD) begin
      st[1] = ins(1, 8, 8, 1, 1, 9, 0, 0); ex[1] = O_STALL | 8'h05;
      st[2] = ins(1, 8, 8, 1, 1, 9, 0, 0); ex[2] = 8'h0A;
      st[3] = ins(0, 0, 0, 0, 0, 0, 0, 0); ex[3] = O_NONE;
      n = 4; sc = 1;
    end else begin
      for (int i = 1; i < 5; i++) begin st[i] = ins(1, 8, 8, 1, 1, 9, 0, 0); ex[i] = O_STALL; end
      ex[4] = O_NONE;
      st[5] = ins(0, 0, 0, 0, 0, 0, 0, 0); ex[5] = O_NONE;
      n = 6; sc = 3;
    end
    for (int i = 0; i < n; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (outs !== e) begin fails++; $display("FAIL load_use row %0d: outs=%b expected %b", i, outs, e); end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt !== sc) begin fails++; $display("FAIL load_use_stall_cnt: got %0d expected %0d", stall_cnt, sc); end
  endtask

  task automatic test_reg_zero();
    stim_t st[3]; logic [7:0] e;
    do_reset();
    st[0] = ins(1, 1, 2, 1, 1, 0, 0, 0);
    st[1] = ins(1, 0, 0, 1, 1, 5, 0, 0);
    st[2] = ins(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); exp_q.push_back(O_NONE);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (outs !== e) begin fails++; $display("FAIL reg_zero row %0d: outs=%b expected %b", i, outs, e); end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt !== '0) begin fails++; $display("FAIL reg_zero_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_redirect_in_hold();
    stim_t st[5]; logic [7:0] ex[5]; logic [7:0] e;
    do_reset();
    st[0] = ins(1, 0, 8, 0, 1, 8, 1, 0); ex[0] = O_NONE;
    st[1] = ins(1, 8, 8, 1, 1, 9, 0, 0); ex[1] = FWD ? 8'hC5 : O_STALL;
    st[2] = ins(1, 8, 8, 1, 1, 9, 0, 1); ex[2] = FWD ? 8'h3A : O_FLUSH;
    st[3] = ins(1, 8, 8, 1, 1, 9, 0, 0); ex[3] = O_FLUSH;
    st[4] = ins(0, 0, 0, 0, 0, 0, 0, 0); ex[4] = O_NONE;
    for (int i = 0; i < 5; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (outs !== e) begin fails++; $display("FAIL redirect_hold row %0d: outs=%b expected %b", i, outs, e); end
      @(posedge clk); #1;
    end
    checks++; if (flush_cnt !== 1) begin fails++; $display("FAIL redirect_hold_flush_cnt: got %0d expected 1", flush_cnt); end
    checks++; if (stall_cnt !== 1) begin fails++; $display("FAIL redirect_hold_stall_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_back_to_back_redirect();
    stim_t st[4]; logic [7:0] ex[4]; logic [7:0] e;
    do_reset();
    st[0] = ins(1, 1, 2, 1, 1, 7, 0, 1); ex[0] = O_FLUSH;
    st[1] = ins(1, 1, 2, 1, 1, 7, 0, 1); ex[1] = O_FLUSH;
    st[2] = ins(1, 1, 2, 1, 1, 7, 0, 0); ex[2] = O_FLUSH;
    st[3] = ins(0, 0, 0, 0, 0, 0, 0, 0); ex[3] = O_NONE;
    for (int i = 0; i < 4; i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (outs !== e) begin fails++; $display("FAIL back_to_back row %0d: outs=%b expected %b", i, outs, e); end
      @(posedge clk); #1;
    end
    checks++; if (flush_cnt !== 2) begin fails++; $display("FAIL back_to_back_flush_cnt: got %0d expected 2", flush_cnt); end
    checks++; if (stall_cnt !== 0) begin fails++; $display("FAIL back_to_back_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] e;
    do_reset();
    apply(ins(1, 0, 3, 0, 1, 3, 1, 0)); exp_q.push_back(O_NONE);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if (outs !== e) begin fails++; $display("FAIL mid_reset_lw: outs=%b expected %b", outs, e); end
    @(posedge clk); #1;
    apply(ins(1, 3, 5, 1, 1, 4, 0, 0)); exp_q.push_back(FWD ? 8'hC4 : O_STALL);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if (outs !== e) begin fails++; $display("FAIL mid_reset_hold1: outs=%b expected %b", outs, e); end
    @(posedge clk); #2;
    rst = 1'b1; exp_q.push_back(O_NONE);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if (outs !== e) begin fails++; $display("FAIL mid_reset_in_rst: outs=%b expected %b", outs, e); end
    checks++; if (stall_cnt !== '0) begin fails++; $display("FAIL mid_reset_stall_cnt: got %0d expected 0", stall_cnt); end
    @(posedge clk); #1;
    rst = 1'b0; exp_q.push_back(O_NONE);
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if (outs !== e) begin fails++; $display("FAIL mid_reset_after: outs=%b expected %b", outs, e); end
    @(posedge clk); #1;
    apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
    checks++; if (stall_cnt !== '0) begin fails++; $display("FAIL mid_reset_issue_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_saturation();
    logic released;
    do_reset();
    for (int p = 0; p < 16; p++) begin
      apply(ins(1, 0, 8, 0, 1, 8, 1, 0));
      @(posedge clk); #1;
      apply(ins(1, 8, 8, 1, 1, 9, 0, 0));
      released = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        @(posedge clk); #1;
        if (!released && !stall) released = 1'b1;
        if (released) break;
      end
      if (!released) begin
        checks++; fails++;
        $display("FAIL sat_stall_release: pair %0d stall=%b expected 0 within 5 cycles", p, stall);
      end
    end
    apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 4'hF) begin fails++; $display("FAIL sat_stall_cnt: got %0d expected 15", stall_cnt); end
    for (int p = 0; p < 18; p++) begin
      apply(ins(0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk); #1;
    end
    apply(ins(0, 0, 0, 0, 0, 0, 0, 0));
    checks++; if (flush_cnt !== 4'hF) begin fails++; $display("FAIL sat_flush_cnt: got %0d expected 15", flush_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_raw_alu();
    test_load_use();
    test_reg_zero();
    test_redirect_in_hold();
    test_back_to_back_redirect();
    test_reset_mid_hold();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
